// File: rtl/friet_pkg.sv
// Shared Friet-PC definitions: state geometry, round-constant table, FSM encoding
// and lane helpers used by the inverse round datapath.
package friet_pkg;

    localparam int FRIET_STATE_W = 384;
    localparam int FRIET_LANE_W  = 128;
    localparam int FRIET_RC_W    = 5;
    localparam int FRIET_RC_N    = 24;
    localparam int FRIET_IDX_W   = $clog2(FRIET_RC_N);

    typedef logic [FRIET_LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } fsm_e;

    // Same table the forward engine walks upward; the inverse engine walks it downward.
    localparam logic [FRIET_RC_W-1:0] FRIET_RC [0:FRIET_RC_N-1] = '{
        5'h01, 5'h12, 5'h05, 5'h14, 5'h0B, 5'h16, 5'h09, 5'h1A,
        5'h03, 5'h18, 5'h0D, 5'h1E, 5'h07, 5'h10, 5'h0F, 5'h11,
        5'h0A, 5'h1C, 5'h06, 5'h13, 5'h0E, 5'h19, 5'h04, 5'h17
    };

    // Result bit i takes x[(i+k) mod 128].
    function automatic lane_t lane_fetch(input lane_t x, input int unsigned k);
        lane_fetch = (x >> k) | (x << (FRIET_LANE_W - k));
    endfunction

    function automatic lane_t rc_mask(input logic [FRIET_RC_W-1:0] rc);
        lane_t m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[4*k]      = rc[k] & ~rc[4];
            m[16 + 4*k] = rc[k] &  rc[4];
        end
        return m;
    endfunction

    function automatic logic [FRIET_RC_W-1:0] rc_lookup(input logic [FRIET_IDX_W-1:0] idx);
        logic [FRIET_RC_W-1:0] rc;
        if (idx < FRIET_IDX_W'(FRIET_RC_N)) begin
            rc = FRIET_RC[idx];
        end else begin
            rc = 5'h00;
        end
        return rc;
    endfunction

endpackage

// File: rtl/friet_pc_inverse_round.sv
// One combinational inverse Friet-PC round: maps a forward-round output back to its
// input for the given round constant. Lanes are a=[127:0], b=[255:128], c=[383:256].
module friet_pc_inverse_round
    import friet_pkg::*;
(
    input  logic [FRIET_STATE_W-1:0] state_i,
    input  logic [FRIET_RC_W-1:0]    rc_i,
    output logic [FRIET_STATE_W-1:0] state_o
);

    lane_t a_in_s;
    lane_t b_in_s;
    lane_t c_in_s;
    lane_t t_s;
    lane_t f_s;
    lane_t a_out_s;
    lane_t cp_s;
    lane_t b_out_s;
    lane_t c_out_s;

    // Undo mixing, then the lane shuffle, then strip the round constant.
    always_comb begin
        a_in_s  = state_i[FRIET_LANE_W-1:0];
        b_in_s  = state_i[2*FRIET_LANE_W-1:FRIET_LANE_W];
        c_in_s  = state_i[3*FRIET_LANE_W-1:2*FRIET_LANE_W];
        t_s     = a_in_s ^ (lane_fetch(c_in_s, 61) & lane_fetch(b_in_s, 92));
        f_s     = b_in_s ^ c_in_s ^ t_s;
        a_out_s = c_in_s ^ lane_fetch(f_s, 48);
        // a[i-1] is a fetch of +127 modulo the lane width.
        cp_s    = f_s ^ lane_fetch(a_out_s, 127);
        b_out_s = t_s ^ a_out_s ^ cp_s;
        c_out_s = cp_s ^ rc_mask(rc_i);
        state_o = {c_out_s, b_out_s, a_out_s};
    end

endmodule

// File: rtl/friet_pc_inverse_permutation.sv
// Iterative inverse Friet-PC permutation: one inverse round per clock, round
// constants consumed from ROUNDS-1 down to 0, valid/ready on both sides.
module friet_pc_inverse_permutation
    import friet_pkg::*;
#(
    parameter int ROUNDS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FRIET_STATE_W-1:0] in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FRIET_STATE_W-1:0] out_state,
    output logic                     busy
);

    localparam logic [FRIET_IDX_W-1:0] IDX_LAST = FRIET_IDX_W'(ROUNDS - 1);

    fsm_e                     fsm_q;
    fsm_e                     fsm_d;
    logic [FRIET_IDX_W-1:0]   idx_q;
    logic [FRIET_IDX_W-1:0]   idx_d;
    logic [FRIET_STATE_W-1:0] state_q;
    logic [FRIET_STATE_W-1:0] state_d;
    logic [FRIET_STATE_W-1:0] round_s;
    logic [FRIET_RC_W-1:0]    rc_s;
    logic                     in_ready_q;
    logic                     in_ready_d;
    logic                     out_valid_q;
    logic                     out_valid_d;
    logic                     busy_q;
    logic                     busy_d;

    assign rc_s = rc_lookup(idx_q);

    friet_pc_inverse_round u_round (
        .state_i (state_q),
        .rc_i    (rc_s),
        .state_o (round_s)
    );

    // Next-state, round counter and state register update.
    always_comb begin
        fsm_d   = fsm_q;
        idx_d   = idx_q;
        state_d = state_q;
        case (fsm_q)
            FSM_IDLE: begin
                if (in_valid) begin
                    fsm_d   = FSM_RUN;
                    idx_d   = IDX_LAST;
                    state_d = in_state;
                end else begin
                    fsm_d   = FSM_IDLE;
                end
            end
            FSM_RUN: begin
                state_d = round_s;
                // Counter stops at zero; the last round hands over to DONE.
                if (idx_q == {FRIET_IDX_W{1'b0}}) begin
                    fsm_d = FSM_DONE;
                end else begin
                    idx_d = idx_q - FRIET_IDX_W'(1);
                end
            end
            FSM_DONE: begin
                if (out_ready) begin
                    fsm_d = FSM_IDLE;
                end else begin
                    fsm_d = FSM_DONE;
                end
            end
            default: begin
                fsm_d = FSM_IDLE;
                idx_d = IDX_LAST;
            end
        endcase
    end

    // Handshake flags are registered, decoded from the upcoming state.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (fsm_d)
            FSM_IDLE: in_ready_d  = 1'b1;
            FSM_RUN:  busy_d      = 1'b1;
            FSM_DONE: out_valid_d = 1'b1;
            default:  in_ready_d  = 1'b0;
        endcase
    end

    // State and flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= FSM_IDLE;
            idx_q       <= IDX_LAST;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = state_q;

endmodule
